code_mem: RTL and testbench

Instruction memory and program loader that sits directly upstream of `controller`. It accepts a BPF program as an AXI-Stream of 8-bit instruction bytes and stores it in a simple dual-port RAM. It serves the controller's registered read port, driving `instr_in` one cycle after `inst_rd_en`. It holds the CPU in a non-running state until a complete program has been loaded.

---
 rtl/axis_cpu_defs.sv | 12 +
 rtl/code_mem_sdp_bram.sv | 33 +++
 rtl/code_mem.sv | 125 ++++++++++++
 tb/tb_code_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_cpu_defs.sv
// Shared definitions for the BPF CPU blocks.
// Holds the code_mem loader FSM state encodings so that monitors and
// neighbouring blocks decode the same values.
package axis_cpu_defs;

    // code_mem loader FSM states
    localparam logic [1:0] CM_EMPTY = 2'd0;  // waiting for the first beat of a program
    localparam logic [1:0] CM_LOAD  = 2'd1;  // storing beats at wr_ptr
    localparam logic [1:0] CM_DRAIN = 2'd2;  // oversized program: discard beats until TLAST
    localparam logic [1:0] CM_RUN   = 2'd3;  // program resident, CPU released

endpackage

// File: rtl/code_mem_sdp_bram.sv
// Simple dual-port RAM: one write port and one registered, read-first read port.
// Latency: read data appears one clock after rd_en. Writes commit on the clock edge.
// Backpressure: none. Both ports accept an access every cycle.
// Ports: clk; we/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered output.
// There is no reset, so synthesis can map this to block RAM.
module sdp_bram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/code_mem.sv
// Instruction memory and AXI-Stream program loader that feeds the controller.
// Latency: instr_out is valid one clock after inst_rd_en. cpu_run rises one clock after the TLAST beat.
// Backpressure: prog_TREADY is high in EMPTY, LOAD and DRAIN and low in RUN and during reset.
// Ports: clk/rst; prog_T* program stream; reload; rd_addr/inst_rd_en/instr_out fetch port;
//        cpu_run, prog_len and ovf_err status outputs.
module code_mem
    import axis_cpu_defs::*;
#(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int INSTR_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_WIDTH-1:0]     prog_TDATA,
    input  logic                       prog_TVALID,
    input  logic                       prog_TLAST,
    output logic                       prog_TREADY,
    input  logic                       reload,
    input  logic [CODE_ADDR_WIDTH-1:0] rd_addr,
    input  logic                       inst_rd_en,
    output logic [INSTR_WIDTH-1:0]     instr_out,
    output logic                       cpu_run,
    output logic [CODE_ADDR_WIDTH:0]   prog_len,
    output logic                       ovf_err
);

    localparam logic [CODE_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [1:0]                 state;
    logic [CODE_ADDR_WIDTH-1:0] wr_ptr;
    logic                       accept;
    logic                       ram_we;
    logic [INSTR_WIDTH-1:0]     ram_rd_data;
    logic                       in_range_q;

    // Ready depends on the state only. The reset term keeps the stream stalled
    // while the control state is being cleared.
    assign prog_TREADY = !rst && (state != CM_RUN);
    assign accept      = prog_TVALID && prog_TREADY;
    // Beats accepted in DRAIN are thrown away.
    assign ram_we      = accept && ((state == CM_EMPTY) || (state == CM_LOAD));

    sdp_bram #(
        .ADDR_WIDTH (CODE_ADDR_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (prog_TDATA),
        .rd_en   (inst_rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CM_EMPTY;
            wr_ptr   <= '0;
            prog_len <= '0;
            ovf_err  <= 1'b0;
            cpu_run  <= 1'b0;
        end else begin
            case (state)
                CM_EMPTY: begin
                    // wr_ptr is always 0 here, so the first beat lands at address 0.
                    if (accept) begin
                        ovf_err <= 1'b0;
                        wr_ptr  <= wr_ptr + 1'b1;
                        if (prog_TLAST) begin
                            prog_len <= {{CODE_ADDR_WIDTH{1'b0}}, 1'b1};
                            cpu_run  <= 1'b1;
                            state    <= CM_RUN;
                        end else begin
                            state <= CM_LOAD;
                        end
                    end
                end
                CM_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (prog_TLAST) begin
                            prog_len <= {1'b0, wr_ptr} + 1'b1;
                            cpu_run  <= 1'b1;
                            state    <= CM_RUN;
                        end else if (wr_ptr == LAST_ADDR) begin
                            // Memory is full and the program has not ended.
                            ovf_err <= 1'b1;
                            state   <= CM_DRAIN;
                        end
                    end
                end
                CM_DRAIN: begin
                    if (accept && prog_TLAST) begin
                        prog_len <= '0;
                        wr_ptr   <= '0;
                        state    <= CM_EMPTY;
                    end
                end
                default: begin  // CM_RUN
                    if (reload) begin
                        cpu_run  <= 1'b0;
                        prog_len <= '0;
                        wr_ptr   <= '0;
                        state    <= CM_EMPTY;
                    end
                end
            endcase
        end
    end

    // The range check is taken when the read is issued and held alongside the
    // RAM output register. An out-of-range fetch then reads as 0 and never
    // returns leftovers from an earlier, longer program.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_range_q <= 1'b0;
        end else if (inst_rd_en) begin
            in_range_q <= ({1'b0, rd_addr} < prog_len);
        end
    end

    assign instr_out = in_range_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_code_mem.sv
module tb_code_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prog_TDATA;
    logic       prog_TVALID;
    logic       prog_TLAST;
    logic       prog_TREADY;
    logic       reload;
    logic [3:0] rd_addr;
    logic       inst_rd_en;
    logic [7:0] instr_out;
    logic       cpu_run;
    logic [4:0] prog_len;
    logic       ovf_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    code_mem #(
        .CODE_ADDR_WIDTH (4),
        .INSTR_WIDTH     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_TDATA  (prog_TDATA),
        .prog_TVALID (prog_TVALID),
        .prog_TLAST  (prog_TLAST),
        .prog_TREADY (prog_TREADY),
        .reload      (reload),
        .rd_addr     (rd_addr),
        .inst_rd_en  (inst_rd_en),
        .instr_out   (instr_out),
        .cpu_run     (cpu_run),
        .prog_len    (prog_len),
        .ovf_err     (ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a falling edge and wait one full cycle so the rising
    // edge in between performs the handshake. TVALID stays high afterwards.
    task automatic send(input logic [7:0] d, input logic last);
        prog_TDATA  = d;
        prog_TLAST  = last;
        prog_TVALID = 1'b1;
        #1;
        chk("tready_before_beat", prog_TREADY, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle();
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
        rd_addr    = a;
        inst_rd_en = 1'b1;
        @(negedge clk);
        inst_rd_en = 1'b0;
        chk(tag, instr_out, exp);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        prog_TDATA = '0; prog_TVALID = 1'b0; prog_TLAST = 1'b0;
        reload = 1'b0; rd_addr = '0; inst_rd_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_tready", prog_TREADY, 1'b0);
        chk("rst_cpu_run", cpu_run, 1'b0);
        chk("rst_prog_len", prog_len, 5'd0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_instr", instr_out, 8'h00);
        rst = 1'b0;
        #1;
        chk("post_rst_tready", prog_TREADY, 1'b1);
        @(negedge clk);

        // Five-byte program 0x11..0x15
        for (int i = 0; i < 5; i++) begin
            send(8'h11 + 8'(i), i == 4);
            if (i < 4) chk("load5_not_running", cpu_run, 1'b0);
        end
        idle();
        chk("load5_cpu_run", cpu_run, 1'b1);
        chk("load5_prog_len", prog_len, 5'd5);
        chk("load5_tready_run", prog_TREADY, 1'b0);
        rd(4'd2, 8'h13, "load5_rd2");
        // Hold: address changes without enable leave the output alone
        rd_addr = 4'd0;
        @(negedge clk);
        chk("hold_rd_en0", instr_out, 8'h13);
        rd_addr = 4'd4;
        @(negedge clk);
        chk("hold_rd_en0_b", instr_out, 8'h13);
        rd(4'd7, 8'h00, "load5_rd7_oob");
        rd(4'd4, 8'h15, "load5_rd4_last");
        rd(4'd5, 8'h00, "load5_rd5_eq_len");

        // In RUN the stream is stalled
        prog_TVALID = 1'b1; prog_TDATA = 8'hEE;
        #1;
        chk("run_tready_vld", prog_TREADY, 1'b0);
        @(negedge clk);
        prog_TVALID = 1'b0;
        chk("run_still_running", cpu_run, 1'b1);
        chk("run_len_kept", prog_len, 5'd5);
        rd(4'd0, 8'h11, "run_rd0_unchanged");

        // Reload then a two-beat program
        pulse_reload();
        chk("reload_cpu_run", cpu_run, 1'b0);
        chk("reload_prog_len", prog_len, 5'd0);
        chk("reload_tready", prog_TREADY, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        idle();
        chk("two_cpu_run", cpu_run, 1'b1);
        chk("two_prog_len", prog_len, 5'd2);
        rd(4'd1, 8'h02, "two_rd1");
        rd(4'd2, 8'h00, "two_rd2_stale_masked");

        // Single-beat program goes straight from EMPTY to RUN
        pulse_reload();
        send(8'hAB, 1'b1);
        idle();
        chk("single_cpu_run", cpu_run, 1'b1);
        chk("single_prog_len", prog_len, 5'd1);
        rd(4'd0, 8'hAB, "single_rd0");
        rd(4'd1, 8'h00, "single_rd1_masked");

        // Overflow: 20 beats into a 16-deep memory
        pulse_reload();
        for (int i = 0; i < 20; i++) begin
            send(8'h20 + 8'(i), i == 19);
            if (i == 14) chk("ovf_before_full", ovf_err, 1'b0);
            if (i == 15) chk("ovf_after_beat16", ovf_err, 1'b1);
            if (i == 15) chk("ovf_not_running", cpu_run, 1'b0);
        end
        idle();
        chk("ovf_sticky", ovf_err, 1'b1);
        chk("ovf_end_len", prog_len, 5'd0);
        chk("ovf_end_cpu_run", cpu_run, 1'b0);
        chk("ovf_end_tready", prog_TREADY, 1'b1);
        pulse_reload();
        chk("ovf_reload_ignored", ovf_err, 1'b1);
        send(8'h31, 1'b0);
        chk("ovf_clear_first_beat", ovf_err, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b1);
        idle();
        chk("ovf_next_len", prog_len, 5'd3);
        chk("ovf_next_run", cpu_run, 1'b1);
        rd(4'd0, 8'h31, "ovf_next_rd0");
        rd(4'd2, 8'h33, "ovf_next_rd2");
        rd(4'd15, 8'h00, "ovf_next_rd15_oob");
        rd(4'd1, 8'h32, "ovf_next_rd1");

        // Reset after 3 of 6 beats
        pulse_reload();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        prog_TDATA = 8'h44;
        rst = 1'b1;
        #1;
        chk("midrst_tready", prog_TREADY, 1'b0);
        chk("midrst_instr", instr_out, 8'h00);
        chk("midrst_len", prog_len, 5'd0);
        chk("midrst_cpu_run", cpu_run, 1'b0);
        chk("midrst_ovf", ovf_err, 1'b0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        send(8'h51, 1'b0);
        send(8'h52, 1'b1);
        idle();
        chk("midrst_next_len", prog_len, 5'd2);
        rd(4'd0, 8'h51, "midrst_next_rd0");
        rd(4'd1, 8'h52, "midrst_next_rd1");

        // Burst with random TVALID gaps
        pulse_reload();
        for (int i = 0; i < 6; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            idle();
            repeat (gap) @(negedge clk);
            send(8'h60 + 8'(i), i == 5);
        end
        idle();
        chk("gap_len", prog_len, 5'd6);
        for (int i = 0; i < 6; i++) begin
            rd(4'(i), 8'h60 + 8'(i), "gap_rd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
